dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-pointer data memory between requester 0 (core load/store) and requester 1 (DMA/test loader). Round-robin arbitration with optional bounded burst lock, same-cycle grant. Drives the memory's write-enable, write-address and shared read-address/write-data bus. Returns registered read data with a per-requester valid pulse.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arb_pick.sv | 41 ++++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, requester id, burst and stats widths.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam int MAX_BURST_DEF = 4;
    localparam int STATS_W       = 16;

    // Burst counter holds 0..mb-1; keep at least one bit.
    function automatic int cnt_w(input int mb);
        return (mb < 3) ? 1 : $clog2(mb);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and optional stats signals of the data-memory arbiter.
// Stats signals exist only when DMEM_ARB_STATS_EN is defined.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
) ();

    logic         Req0, Req1;
    logic         We0, We1;
    logic         Lock0, Lock1;
    logic [A-1:0] Addr0, Addr1;
    logic [W-1:0] WData0, WData1;
    logic         Gnt0, Gnt1;
    logic         RValid0, RValid1;
    logic [W-1:0] RData;
    logic         MemWe;
    logic [A-1:0] MemWAddr;
    logic [W-1:0] MemBus;
    logic [W-1:0] MemRData;
`ifdef DMEM_ARB_STATS_EN
    logic [STATS_W-1:0] GntCnt0, GntCnt1, ConflictCnt;
`endif

    modport master (
        output Req0, Req1, We0, We1, Lock0, Lock1,
        output Addr0, Addr1, WData0, WData1,
        output MemRData,
        input  Gnt0, Gnt1, RValid0, RValid1, RData,
        input  MemWe, MemWAddr, MemBus
`ifdef DMEM_ARB_STATS_EN
        , input GntCnt0, GntCnt1, ConflictCnt
`endif
    );

    modport slave (
        input  Req0, Req1, We0, We1, Lock0, Lock1,
        input  Addr0, Addr1, WData0, WData1,
        input  MemRData,
        output Gnt0, Gnt1, RValid0, RValid1, RData,
        output MemWe, MemWAddr, MemBus
`ifdef DMEM_ARB_STATS_EN
        , output GntCnt0, GntCnt1, ConflictCnt
`endif
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: round-robin with bounded burst lock.
// One-hot grant; reset gating is applied by the caller.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CW        = cnt_w(MAX_BURST)
) (
    input  logic [1:0]    req,
    input  logic [1:0]    lock,
    input  arb_state_e    state,
    input  req_id_t       last_win,
    input  logic [CW-1:0] burst_cnt,
    output logic [1:0]    gnt
);

    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST - 1);

    logic both;
    logic below;
    logic hold0;
    logic hold1;

    assign both  = &req;
    assign below = burst_cnt < BMAX;
    assign hold0 = both & lock[0] & below & (state == OWN0);
    assign hold1 = both & lock[1] & below & (state == OWN1);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b00): gnt = 2'b00;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            hold0:          gnt = 2'b01;
            hold1:          gnt = 2'b10;
            default:        gnt = last_win ? 2'b01 : 2'b10;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: same-cycle grant, memory mux, registered reads.
// DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int A         = 8,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic           Clk,
    input logic           Reset,
    dmem_arbiter_if.slave bus
);

    localparam int            CW   = cnt_w(MAX_BURST);
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST - 1);

    arb_state_e    state;
    req_id_t       last_win;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_inc;
    logic          rv0_q, rv1_q;
    logic [W-1:0]  rdata_q;
    logic [1:0]    pick;
    logic [1:0]    gnt;
    logic          rd_go;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_pick (
        .req       ({bus.Req1, bus.Req0}),
        .lock      ({bus.Lock1, bus.Lock0}),
        .state     (state),
        .last_win  (last_win),
        .burst_cnt (burst_cnt),
        .gnt       (pick)
    );

    assign gnt       = Reset ? pick : 2'b00;
    assign rd_go     = (gnt[0] & ~bus.We0) | (gnt[1] & ~bus.We1);
    assign burst_inc = (burst_cnt == BMAX) ? BMAX : burst_cnt + 1'b1;

    assign bus.Gnt0    = gnt[0];
    assign bus.Gnt1    = gnt[1];
    // A result still in flight when reset lands is suppressed.
    assign bus.RValid0 = rv0_q & Reset;
    assign bus.RValid1 = rv1_q & Reset;
    assign bus.RData   = rdata_q;

    always_comb begin
        bus.MemWe    = 1'b0;
        bus.MemWAddr = '0;
        bus.MemBus   = '0;
        unique case (1'b1)
            gnt[0]: begin
                bus.MemWe    = bus.We0;
                bus.MemWAddr = bus.Addr0;
                bus.MemBus   = bus.We0 ? bus.WData0 : W'(bus.Addr0);
            end
            gnt[1]: begin
                bus.MemWe    = bus.We1;
                bus.MemWAddr = bus.Addr1;
                bus.MemBus   = bus.We1 ? bus.WData1 : W'(bus.Addr1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            last_win  <= 1'b1;
            burst_cnt <= '0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rv0_q <= gnt[0] & ~bus.We0;
            rv1_q <= gnt[1] & ~bus.We1;
            if (rd_go) begin
                rdata_q <= bus.MemRData;
            end
            unique case (1'b1)
                gnt[0]: begin
                    state     <= OWN0;
                    last_win  <= 1'b0;
                    burst_cnt <= (state == OWN0) ? burst_inc : '0;
                end
                gnt[1]: begin
                    state     <= OWN1;
                    last_win  <= 1'b1;
                    burst_cnt <= (state == OWN1) ? burst_inc : '0;
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STATS_W-1:0] gcnt0, gcnt1, ccnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
            ccnt  <= '0;
        end else begin
            if (gnt[0] && gcnt0 != '1) begin
                gcnt0 <= gcnt0 + 1'b1;
            end
            if (gnt[1] && gcnt1 != '1) begin
                gcnt1 <= gcnt1 + 1'b1;
            end
            if (bus.Req0 && bus.Req1 && ccnt != '1) begin
                ccnt <= ccnt + 1'b1;
            end
        end
    end

    assign bus.GntCnt0     = gcnt0;
    assign bus.GntCnt1     = gcnt1;
    assign bus.ConflictCnt = ccnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a streak/queue-level model.
// Stats checks are included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    localparam int W  = 8;
    localparam int A  = 8;
    localparam int MB = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    always #5 Clk = ~Clk;

    dmem_arbiter_if #(.W(W), .A(A)) bus ();

    dmem_arbiter #(
        .W         (W),
        .A         (A),
        .MAX_BURST (MB)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [W-1:0] mem [256];

    assign bus.MemRData = mem[bus.MemBus];

    always @(posedge Clk) begin
        if (bus.MemWe) mem[bus.MemWAddr] <= bus.MemBus;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: owner of last cycle, length of its grant streak.
    int           owner    = -1;
    int           last_win = 1;
    int           streak   = 0;
    bit           m_rv [2] = '{0, 0};
    logic [W-1:0] m_rdata  = '0;
    logic [W-1:0] m_mem [256];
    int           m_gc [2] = '{0, 0};
    int           m_cc     = 0;
    int           g_last   = -1;

    always @(negedge Clk) begin
        bit           r  [2];
        bit           we [2];
        bit           lk [2];
        logic [A-1:0] ad [2];
        logic [W-1:0] wd [2];
        int           w;
        r  = '{bus.Req0, bus.Req1};
        we = '{bus.We0, bus.We1};
        lk = '{bus.Lock0, bus.Lock1};
        ad = '{bus.Addr0, bus.Addr1};
        wd = '{bus.WData0, bus.WData1};
        w  = -1;
        if (Reset) begin
            if (r[0] && r[1]) begin
                if (owner >= 0 && lk[owner] && streak < MB) w = owner;
                else w = 1 - last_win;
            end else if (r[0]) w = 0;
            else if (r[1]) w = 1;
        end
        chk("Gnt0", bus.Gnt0, w == 0);
        chk("Gnt1", bus.Gnt1, w == 1);
        chk("MemWe", bus.MemWe, (w >= 0) ? we[w] : 1'b0);
        chk("MemWAddr", bus.MemWAddr, (w >= 0) ? ad[w] : '0);
        chk("MemBus", bus.MemBus,
            (w < 0) ? '0 : (we[w] ? wd[w] : ad[w]));
        chk("RValid0", bus.RValid0, m_rv[0] & Reset);
        chk("RValid1", bus.RValid1, m_rv[1] & Reset);
        chk("RData", bus.RData, m_rdata);
`ifdef DMEM_ARB_STATS_EN
        chk("GntCnt0", bus.GntCnt0, m_gc[0]);
        chk("GntCnt1", bus.GntCnt1, m_gc[1]);
        chk("ConflictCnt", bus.ConflictCnt, m_cc);
`endif
        if (!Reset) begin
            owner    = -1;
            last_win = 1;
            streak   = 0;
            m_rv     = '{0, 0};
            m_rdata  = '0;
            m_gc     = '{0, 0};
            m_cc     = 0;
        end else begin
            m_rv[0] = (w == 0) && !we[0];
            m_rv[1] = (w == 1) && !we[1];
            if (r[0] && r[1] && m_cc < 65535) m_cc++;
            if (w >= 0) begin
                if (m_gc[w] < 65535) m_gc[w]++;
                if (we[w]) m_mem[ad[w]] = wd[w];
                else m_rdata = m_mem[ad[w]];
                streak   = (owner == w) ? streak + 1 : 1;
                owner    = w;
                last_win = w;
            end else begin
                owner  = -1;
                streak = 0;
            end
        end
        g_last = w;
    end

    task automatic cyc(input bit rst,
                       input bit r0, input bit w0, input bit l0,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input bit l1,
                       input logic [7:0] a1, input logic [7:0] d1);
        @(posedge Clk);
        #1;
        Reset      = rst;
        bus.Req0   = r0;
        bus.We0    = w0;
        bus.Lock0  = l0;
        bus.Addr0  = a0;
        bus.WData0 = d0;
        bus.Req1   = r1;
        bus.We1    = w1;
        bus.Lock1  = l1;
        bus.Addr1  = a1;
        bus.WData1 = d1;
        @(negedge Clk);
        #1;
    endtask

    task automatic idle(input bit rst);
        cyc(rst, 0, 0, 0, 8'h0, 8'h0, 0, 0, 0, 8'h0, 8'h0);
    endtask

    bit           pr [2];
    bit           pw [2];
    bit           pl [2];
    logic [7:0]   pa [2];
    logic [7:0]   pd [2];
    logic [5:0]   rr_pat;
    logic [5:0]   lk_pat;
    bit           rst_r;

    initial begin
        bus.Req0 = 0; bus.We0 = 0; bus.Lock0 = 0;
        bus.Addr0 = '0; bus.WData0 = '0;
        bus.Req1 = 0; bus.We1 = 0; bus.Lock1 = 0;
        bus.Addr1 = '0; bus.WData1 = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'($urandom);
            m_mem[i] = mem[i];
        end
        mem[16]   = 8'hA5;
        m_mem[16] = 8'hA5;

        idle(0);
        cyc(0, 1, 0, 0, 8'h10, 8'h0, 1, 0, 0, 8'h11, 8'h0);
        chk("rst_gnt0", bus.Gnt0, 0);
        chk("rst_gnt1", bus.Gnt1, 0);
        chk("rst_rdata", bus.RData, 8'h00);

        cyc(1, 1, 0, 0, 8'h10, 8'h0, 0, 0, 0, 8'h0, 8'h0);
        chk("rd_gnt0", bus.Gnt0, 1);
        chk("rd_membus", bus.MemBus, 8'h10);
        chk("rd_memwe", bus.MemWe, 0);
        idle(1);
        chk("rd_rvalid0", bus.RValid0, 1);
        chk("rd_rdata", bus.RData, 8'hA5);

        cyc(1, 0, 0, 0, 8'h0, 8'h0, 1, 1, 0, 8'h20, 8'h3C);
        chk("wr_memwe", bus.MemWe, 1);
        chk("wr_waddr", bus.MemWAddr, 8'h20);
        chk("wr_membus", bus.MemBus, 8'h3C);
        cyc(1, 0, 0, 0, 8'h0, 8'h0, 1, 0, 0, 8'h20, 8'h0);
        chk("rb_gnt1", bus.Gnt1, 1);
        idle(1);
        chk("rb_rvalid1", bus.RValid1, 1);
        chk("rb_rvalid0", bus.RValid0, 0);
        chk("rb_rdata", bus.RData, 8'h3C);

        idle(0);
        idle(0);
        rr_pat = 6'b010101;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 0, 8'h01, 8'h0, 1, 0, 0, 8'h02, 8'h0);
            chk("rr_gnt0", bus.Gnt0, rr_pat[i]);
        end

        idle(0);
        idle(0);
        lk_pat = 6'b101111;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 1, 8'h03, 8'h0, 1, 0, 0, 8'h04, 8'h0);
            chk("lock_gnt0", bus.Gnt0, lk_pat[i]);
        end

        idle(0);
        idle(0);
        cyc(1, 1, 0, 0, 8'h10, 8'h0, 0, 0, 0, 8'h0, 8'h0);
        chk("rr_pre_gnt0", bus.Gnt0, 1);
        cyc(0, 1, 0, 0, 8'h10, 8'h0, 1, 0, 0, 8'h11, 8'h0);
        chk("rst_rd_gnt0", bus.Gnt0, 0);
        chk("rst_rd_rvalid0", bus.RValid0, 0);
        chk("rst_rd_memwe", bus.MemWe, 0);
        cyc(1, 1, 0, 0, 8'h10, 8'h0, 1, 0, 0, 8'h11, 8'h0);
        chk("post_rst_rdata", bus.RData, 8'h00);
        chk("post_rst_rvalid0", bus.RValid0, 0);
        chk("post_rst_gnt0", bus.Gnt0, 1);

`ifdef DMEM_ARB_STATS_EN
        idle(0);
        idle(0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 8'h05, 8'h0, 1, 0, 0, 8'h06, 8'h0);
        end
        idle(1);
        chk("st_conflict", bus.ConflictCnt, 16'd10);
        chk("st_gnt0", bus.GntCnt0, 16'd5);
        chk("st_gnt1", bus.GntCnt1, 16'd5);
`endif

        pr = '{0, 0};
        pw = '{0, 0};
        pl = '{0, 0};
        pa = '{8'h0, 8'h0};
        pd = '{8'h0, 8'h0};
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (!pr[x] || g_last == x) begin
                    pr[x] = ($urandom % 4) != 0;
                    pw[x] = ($urandom % 3) == 0;
                    pl[x] = ($urandom % 2) == 0;
                    pa[x] = 8'($urandom % 32);
                    pd[x] = 8'($urandom);
                end else if (($urandom % 16) == 0) begin
                    pr[x] = 0;
                end
            end
            rst_r = ($urandom % 150) != 0;
            cyc(rst_r, pr[0], pw[0], pl[0], pa[0], pd[0],
                pr[1], pw[1], pl[1], pa[1], pd[1]);
        end
        idle(1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
